apb_slave: RTL and testbench

APB completer that answers transfers issued by the team's `apb_master`. It decodes one APB transfer at a time into an internal word-addressed memory, inserts a configurable number of wait states, and flags out-of-range accesses with `pslverr`. It sits on the peripheral side of the APB bus as the reference target for master bring-up and for system-level tests.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_slave_mem.sv | 54 +++++
 rtl/apb_slave.sv | 195 +++++++++++++++++++
 tb/tb_apb_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//
// Definitions shared by apb_slave and apb_master:
//   APB_ADDR_WIDTH   default width of paddr (word address)
//   APB_DATA_WIDTH   default width of pwdata / prdata
//   WAIT_CNT_WIDTH   width of the completer wait-state counter
//   MAX_WAIT_CYCLES  largest wait-state count the counter can hold
//   apb_state_t      completer FSM state encoding
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_WIDTH  = 10;
    localparam int APB_DATA_WIDTH  = 32;

    localparam int WAIT_CNT_WIDTH  = 4;
    localparam int MAX_WAIT_CYCLES = (1 << WAIT_CNT_WIDTH) - 1;

    // IDLE: waiting for a setup phase.
    // WAIT: counting down inserted wait states (pready low).
    // DONE: pready high for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
//
// Word-addressed storage behind the APB completer.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high; clears every word and rd_data
//   wr_en     write strobe; wr_data is stored at wr_addr on the edge
//   wr_addr   write word address
//   wr_data   write data
//   rd_en     read strobe; rd_data is loaded on the edge
//   rd_addr   read word address
//   rd_zero   when set together with rd_en, rd_data is loaded with 0
//             instead of the addressed word (errored read)
//   rd_data   registered read data; holds between read strobes
// ---------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [MEM_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [MEM_AW-1:0]     rd_addr,
    input  logic                  rd_zero,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset has priority over both ports, so a write or read strobe that
    // coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= rd_zero ? '0 : mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//
// APB completer serving one transfer at a time out of an internal
// DEPTH x DATA_WIDTH word memory, with WAIT_CYCLES inserted wait states and
// pslverr on out-of-range word addresses.
//
// Parameters:
//   ADDR_WIDTH   width of paddr (word address)
//   DATA_WIDTH   width of pwdata / prdata
//   DEPTH        number of words; legal addresses 0..DEPTH-1
//   WAIT_CYCLES  access cycles with pready low before completion (0..15)
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset (also clears the memory)
//   pselx    completer select
//   penable  access-phase indicator
//   pwrite   1 = write, 0 = read
//   paddr    word address
//   pwdata   write data
//   pready   transfer complete (registered)
//   prdata   read data (registered, holds until the next read completes)
//   pslverr  error response (registered, only while pready is high)
//
// Handshake: a transfer starts with a setup phase (pselx=1, penable=0), in
// which address, direction and write data are captured; everything after
// that is decoded from the captured copies. The completer holds pready low
// for WAIT_CYCLES access cycles and then raises it for exactly one cycle.
// The transfer completes on the edge where pselx, penable and pready are
// all high; that edge is where a write lands in memory. Dropping pselx
// before completion abandons the transfer with no side effects.
// ---------------------------------------------------------------------------
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
        $error("apb_slave: WAIT_CYCLES must be within 0..15");
    end

    if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("apb_slave: DEPTH must be within 1..2**ADDR_WIDTH");
    end

    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} >= (ADDR_WIDTH + 1)'(DEPTH);
    endfunction

    // -----------------------------------------------------------------------
    // State, counter and capture registers
    // -----------------------------------------------------------------------
    apb_state_t                state;
    apb_state_t                state_next;
    logic [WAIT_CNT_WIDTH-1:0] cnt;
    logic [WAIT_CNT_WIDTH-1:0] cnt_next;
    logic                      capture;

    logic [ADDR_WIDTH-1:0]     cap_addr;
    logic                      cap_write;
    logic [DATA_WIDTH-1:0]     cap_wdata;
    logic                      cap_err;

    // View of the transfer being decoded on this edge. With WAIT_CYCLES=0
    // the edge that captures the setup phase is also the edge that enters
    // DONE, so the read and error decode must look through to the bus.
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic                      cur_write;
    logic                      cur_err;
    logic                      enter_done;

    logic                      mem_wr_en;
    logic                      mem_rd_en;

    assign cur_addr   = capture ? paddr  : cap_addr;
    assign cur_write  = capture ? pwrite : cap_write;
    assign cur_err    = out_of_range(cur_addr);
    assign cap_err    = out_of_range(cap_addr);
    assign enter_done = (state_next == DONE);

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;

        case (state)
            IDLE: begin
                if (pselx && !penable) begin
                    capture    = 1'b1;
                    cnt_next   = WAIT_LOAD;
                    state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end

            WAIT: begin
                cnt_next = cnt - 1'b1;
                if (!pselx) begin
                    // Requester walked away; nothing is written or read.
                    state_next = IDLE;
                end else if (cnt == WAIT_CNT_WIDTH'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state register, capture registers and response flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                cap_addr  <= paddr;
                cap_write <= pwrite;
                cap_wdata <= pwdata;
            end
            // Both flags track DONE, so pslverr can never outlive pready.
            pready  <= enter_done;
            pslverr <= enter_done && cur_err;
        end
    end

    // -----------------------------------------------------------------------
    // Memory ports
    // -----------------------------------------------------------------------
    // The write lands on the completing edge, and only if the requester is
    // still presenting the access phase.
    assign mem_wr_en = (state == DONE) && pselx && penable && pready
                       && cap_write && !cap_err;

    // The read is taken on the edge entering DONE so prdata is valid for the
    // whole pready cycle; an errored read returns 0.
    assign mem_rd_en = enter_done && !cur_write;

    apb_slave_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_AW     (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_wr_en),
        .wr_addr (cap_addr[MEM_AW-1:0]),
        .wr_data (cap_wdata),
        .rd_en   (mem_rd_en),
        .rd_addr (cur_addr[MEM_AW-1:0]),
        .rd_zero (cur_err),
        .rd_data (prdata)
    );

endmodule

// File: tb/tb_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_slave
//
// Four completers with WAIT_CYCLES = 0, 1, 2, 3 share one clock; each has its
// own bus and reset. Instance k therefore answers every complete transfer
// with pready rising k+1 cycles after the setup phase.
// ---------------------------------------------------------------------------
module tb_apb_slave;
    import apb_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    // -----------------------------------------------------------------------
    // Clock / reset, bus signals, DUTs
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [N];
    logic          psel  [N];
    logic          pen   [N];
    logic          pwr   [N];
    logic [AW-1:0] paddr [N];
    logic [DW-1:0] pwd   [N];
    logic          prdy  [N];
    logic [DW-1:0] prd   [N];
    logic          perr  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        apb_slave #(
            .ADDR_WIDTH  (AW),
            .DATA_WIDTH  (DW),
            .DEPTH       (DEPTH),
            .WAIT_CYCLES (g)
        ) u_dut (
            .clk     (clk),
            .reset   (rst[g]),
            .pselx   (psel[g]),
            .penable (pen[g]),
            .pwrite  (pwr[g]),
            .paddr   (paddr[g]),
            .pwdata  (pwd[g]),
            .pready  (prdy[g]),
            .prdata  (prd[g]),
            .pslverr (perr[g])
        );
    end

    // -----------------------------------------------------------------------
    // Scoreboard: reference memory image and last completed read per DUT
    // -----------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [DW-1:0] ref_mem [N][DEPTH];
    logic [DW-1:0] last_rd [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[k][i] = '0;
        end
        last_rd[k] = '0;
    endtask

    // Outcome of one complete transfer: out-of-range addresses error, errored
    // writes are dropped, errored reads return 0, and prdata keeps the last
    // read value across writes.
    task automatic model_xfer(input int k, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d,
                              output logic [DW-1:0] exp_rd, output logic exp_err);
        exp_err = (int'(a) >= DEPTH);
        if (wr) begin
            if (!exp_err) ref_mem[k][int'(a)] = d;
            exp_rd = last_rd[k];
        end else begin
            exp_rd     = exp_err ? '0 : ref_mem[k][int'(a)];
            last_rd[k] = exp_rd;
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver: one complete transfer on bus k, checking timing on the way.
    // Entered anywhere before a rising edge; leaves mid-cycle after the
    // cycle following DONE has been sampled, so calls chain back-to-back.
    // -----------------------------------------------------------------------
    task automatic run_xfer(input int k, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output logic err);
        int lat;
        bit got;
        rd  = '0;
        err = 1'b0;
        psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr; paddr[k] = a; pwd[k] = d;
        @(posedge clk); #1;
        pen[k] = 1'b1;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (prdy[k] === 1'b1) begin
                got = 1'b1;
                rd  = prd[k];
                err = perr[k];
            end else begin
                chk("slverr_low_while_waiting", 32'(perr[k]), 32'd0);
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("xfer_completed", 32'(got), 32'd1);
        chk("ready_latency", 32'(lat), 32'(k + 1));
        @(posedge clk); #1;
        psel[k] = 1'b0; pen[k] = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", 32'(prdy[k]), 32'd0);
    endtask

    task automatic do_xfer(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output logic err);
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        run_xfer(k, wr, a, d, rd, err);
        model_xfer(k, wr, a, d, exp_rd, exp_err);
        if (wr) begin
            chk("model_wr_slverr", 32'(err), 32'(exp_err));
            chk("model_prdata_hold", rd, exp_rd);
        end else begin
            chk("model_rd_slverr", 32'(err), 32'(exp_err));
            chk("model_rd_data", rd, exp_rd);
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        int            k;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;   // prdata in the pready cycle
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        logic [DW-1:0] junk_rd;
        logic          junk_err;
        bit            seen;
        bit            got;

        // ---------------- clock / reset ----------------
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0;
            paddr[k] = '0; pwd[k] = '0;
            model_reset(k);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("reset_pready", 32'(prdy[k]), 32'd0);
            chk("reset_pslverr", 32'(perr[k]), 32'd0);
            chk("reset_prdata", prd[k], 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        @(negedge clk);

        // ---------------- table-driven transfers ----------------
        // k=1: write/read 0x010
        vecs.push_back('{1, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        // k=0: back-to-back writes then reads
        vecs.push_back('{0, 1'b1, 10'h000, 32'h1, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 10'h001, 32'h2, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 10'h002, 32'h3, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 10'h003, 32'h4, 32'h0, 1'b0});
        vecs.push_back('{0, 1'b0, 10'h000, 32'h0, 32'h1, 1'b0});
        vecs.push_back('{0, 1'b0, 10'h001, 32'h0, 32'h2, 1'b0});
        vecs.push_back('{0, 1'b0, 10'h002, 32'h0, 32'h3, 1'b0});
        vecs.push_back('{0, 1'b0, 10'h003, 32'h0, 32'h4, 1'b0});
        // k=1: first out-of-range address, no aliasing onto word 0
        vecs.push_back('{1, 1'b1, 10'h100, 32'h12345678, 32'hDEADBEEF, 1'b1});
        vecs.push_back('{1, 1'b0, 10'h100, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1, 1'b0, 10'h000, 32'h0,        32'h0,        1'b0});
        // boundaries: top of the address space and the last legal word
        vecs.push_back('{3, 1'b1, 10'h3FF, 32'hCAFEF00D, 32'h0,        1'b1});
        vecs.push_back('{2, 1'b1, 10'h0FF, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b0, 10'h0FF, 32'h0,        32'hCAFEF00D, 1'b0});

        foreach (vecs[i]) begin
            do_xfer(vecs[i].k, vecs[i].wr, vecs[i].a, vecs[i].d, rd, err);
            chk("vec_prdata", rd, vecs[i].exp_rd);
            chk("vec_pslverr", 32'(err), 32'(vecs[i].exp_err));
        end

        // ---------------- abort: pselx dropped in 2nd access cycle (k=3) ----
        psel[3] = 1'b1; pen[3] = 1'b0; pwr[3] = 1'b1;
        paddr[3] = 10'h020; pwd[3] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        pen[3] = 1'b1;
        @(posedge clk); #1;
        psel[3] = 1'b0; pen[3] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (prdy[3] !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_pready", 32'(seen), 32'd0);
        chk("abort_state_idle", 32'(g_dut[3].u_dut.state), 32'(IDLE));
        do_xfer(3, 1'b0, 10'h020, 32'h0, rd, err);
        chk("abort_no_write", rd, 32'h0);

        // ---------------- reset mid-write (k=1) ----------------
        do_xfer(1, 1'b1, 10'h005, 32'h55, rd, err);
        do_xfer(1, 1'b0, 10'h005, 32'h0, rd, err);
        chk("pre_reset_read", rd, 32'h55);
        psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1;
        paddr[1] = 10'h006; pwd[1] = 32'hFF;
        @(posedge clk); #1;
        pen[1] = 1'b1; rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0; psel[1] = 1'b0; pen[1] = 1'b0;
        @(negedge clk);
        chk("midreset_pready", 32'(prdy[1]), 32'd0);
        chk("midreset_pslverr", 32'(perr[1]), 32'd0);
        chk("midreset_prdata", prd[1], 32'd0);
        model_reset(1);
        do_xfer(1, 1'b0, 10'h005, 32'h0, rd, err);
        chk("reset_cleared_005", rd, 32'h0);
        do_xfer(1, 1'b0, 10'h006, 32'h0, rd, err);
        chk("reset_dropped_006", rd, 32'h0);

        // ---------------- bus changes during access cycles (k=2) ----------
        do_xfer(2, 1'b1, 10'h031, 32'h11, rd, err);
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1;
        paddr[2] = 10'h030; pwd[2] = 32'h77;
        @(posedge clk); #1;
        pen[2] = 1'b1; pwr[2] = 1'b0; paddr[2] = 10'h031; pwd[2] = 32'h99;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (prdy[2] === 1'b1) begin
                got = 1'b1;
                chk("captured_addr_no_err", 32'(perr[2]), 32'd0);
            end else begin
                @(posedge clk); #1;
                paddr[2] = (c % 2 == 0) ? 10'h100 : 10'h031;
                pwd[2]   = $urandom;
            end
        end
        chk("mid_change_completed", 32'(got), 32'd1);
        @(posedge clk); #1;
        psel[2] = 1'b0; pen[2] = 1'b0;
        model_xfer(2, 1'b1, 10'h030, 32'h77, junk_rd, junk_err);
        @(negedge clk);
        do_xfer(2, 1'b0, 10'h030, 32'h0, rd, err);
        chk("captured_data_written", rd, 32'h77);
        do_xfer(2, 1'b0, 10'h031, 32'h0, rd, err);
        chk("altered_addr_untouched", rd, 32'h11);

        // ---------------- randomized traffic vs reference model ----------
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 20; t++) begin
                logic          wr;
                logic [AW-1:0] a;
                wr = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(250, 270));
                else                          a = AW'($urandom_range(0, 15));
                do_xfer(k, wr, a, $urandom, rd, err);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case a wait above never resolves.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test (%0d checks, %0d failures)",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
